// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - 640x480@60 timing constants and window helper shared by the raster and renderers
package vga_sync_gen_pkg;

  // Board clocks per pixel (100 MHz board clock -> 25 MHz pixel clock)
  localparam int DEF_CLK_DIV     = 4;

  // Horizontal timing in pixel clocks
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_VIS_START = 144;
  localparam int DEF_H_VIS_END   = 784;

  // Vertical timing in lines
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_VIS_START = 35;
  localparam int DEF_V_VIS_END   = 515;

  // Half-open range test [lo, hi) on unsigned 16-bit raster coordinates
  function automatic logic in_span(input logic [15:0] x,
                                   input logic [15:0] lo,
                                   input logic [15:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// rtl/vga_pix_tick.sv - board-clock divider producing a one-clock pixel enable
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;

  // Next divider value: count 0..CLK_DIV-1 and wrap
  always_comb begin
    div_nxt = div_cnt + 1'b1;
    if (div_cnt == DIV_LAST) begin
      div_nxt = '0;
    end
  end

  // pix_tick is registered from the next count so it is glitch-free and low in reset;
  // with CLK_DIV = 1 the next count is always the last one, so the tick holds at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running VGA raster: H/V counters, syncs, video_on and frame_start
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_VIS_START = DEF_H_VIS_START,
  parameter int H_VIS_END   = DEF_H_VIS_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_VIS_START = DEF_V_VIS_START,
  parameter int V_VIS_END   = DEF_V_VIS_END
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        Hsync,
  output logic        Vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SW    = 16'(H_SYNC);
  localparam logic [15:0] V_SW    = 16'(V_SYNC);
  localparam logic [15:0] H_VS    = 16'(H_VIS_START);
  localparam logic [15:0] H_VE    = 16'(H_VIS_END);
  localparam logic [15:0] V_VS    = 16'(V_VIS_START);
  localparam logic [15:0] V_VE    = 16'(V_VIS_END);

  logic [15:0] h_nxt;
  logic [15:0] v_nxt;
  logic        frame_wrap;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  // Next raster position: step one pixel per tick, wrap line then frame
  always_comb begin
    h_nxt      = H_Counter_Value;
    v_nxt      = V_Counter_Value;
    frame_wrap = 1'b0;
    if (pix_tick) begin
      if (H_Counter_Value == H_LAST) begin
        h_nxt = '0;
        if (V_Counter_Value == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = V_Counter_Value + 16'd1;
        end
      end else begin
        h_nxt = H_Counter_Value + 16'd1;
      end
    end
  end

  // Counters and decodes share one register stage so syncs never skew from the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      H_Counter_Value <= '0;
      V_Counter_Value <= '0;
      Hsync           <= 1'b0;
      Vsync           <= 1'b0;
      video_on        <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      H_Counter_Value <= h_nxt;
      V_Counter_Value <= v_nxt;
      Hsync           <= ~(h_nxt < H_SW);
      Vsync           <= ~(v_nxt < V_SW);
      video_on        <= in_span(h_nxt, H_VS, H_VE) && in_span(v_nxt, V_VS, V_VE);
      frame_start     <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

  // Reduced raster used where full 640x480 frames would take too long
  localparam int S_HT  = 20;
  localparam int S_HS  = 3;
  localparam int S_HVS = 5;
  localparam int S_HVE = 17;
  localparam int S_VT  = 12;
  localparam int S_VS  = 2;
  localparam int S_VVS = 4;
  localparam int S_VVE = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f_n, rst_s_n;
  logic f_pix, f_hs, f_vs, f_vo, f_fs;
  logic s_pix, s_hs, s_vs, s_vo, s_fs;
  logic [15:0] f_h, f_v, s_h, s_v;

  int nvec = 0;
  int nerr = 0;

  vga_sync_gen u_full (
    .clk             (clk),
    .rst_n           (rst_f_n),
    .pix_tick        (f_pix),
    .H_Counter_Value (f_h),
    .V_Counter_Value (f_v),
    .Hsync           (f_hs),
    .Vsync           (f_vs),
    .video_on        (f_vo),
    .frame_start     (f_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
    .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE)
  ) u_small (
    .clk             (clk),
    .rst_n           (rst_s_n),
    .pix_tick        (s_pix),
    .H_Counter_Value (s_h),
    .V_Counter_Value (s_v),
    .Hsync           (s_hs),
    .Vsync           (s_vs),
    .video_on        (s_vo),
    .frame_start     (s_fs)
  );

  task automatic sample(input bit sm, output logic p, output logic [15:0] h, output logic [15:0] v,
                        output logic hs, output logic vs, output logic vo, output logic fs);
    p  = sm ? s_pix : f_pix;
    h  = sm ? s_h   : f_h;
    v  = sm ? s_v   : f_v;
    hs = sm ? s_hs  : f_hs;
    vs = sm ? s_vs  : f_vs;
    vo = sm ? s_vo  : f_vo;
    fs = sm ? s_fs  : f_fs;
  endtask

  task automatic test_reset();
    logic p, hs, vs, vo, fs;
    logic [15:0] h, v;
    rst_f_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int sm = 0; sm < 2; sm++) begin
      sample(sm[0], p, h, v, hs, vs, vo, fs);
      nvec++; if (p  !== 1'b0)  begin nerr++; $display("FAIL reset_pix[%0d]: got %b expected 0", sm, p); end
      nvec++; if (h  !== 16'd0) begin nerr++; $display("FAIL reset_h[%0d]: got %0d expected 0", sm, h); end
      nvec++; if (v  !== 16'd0) begin nerr++; $display("FAIL reset_v[%0d]: got %0d expected 0", sm, v); end
      nvec++; if (hs !== 1'b0)  begin nerr++; $display("FAIL reset_hsync[%0d]: got %b expected 0", sm, hs); end
      nvec++; if (vs !== 1'b0)  begin nerr++; $display("FAIL reset_vsync[%0d]: got %b expected 0", sm, vs); end
      nvec++; if (vo !== 1'b0)  begin nerr++; $display("FAIL reset_video_on[%0d]: got %b expected 0", sm, vo); end
      nvec++; if (fs !== 1'b0)  begin nerr++; $display("FAIL reset_frame_start[%0d]: got %b expected 0", sm, fs); end
    end
  endtask

  // Releases reset at a falling edge, then checks the first 12 clocks cycle by cycle
  task automatic test_divider(input bit sm);
    logic p, hs, vs, vo, fs;
    logic [15:0] h, v;
    logic exp_p, exp_hs;
    int exp_h;
    int sync_w;
    sync_w = sm ? S_HS : 96;
    if (sm) rst_s_n = 1'b1; else rst_f_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sm, p, h, v, hs, vs, vo, fs);
      exp_p  = ((k % 4) == 3);
      exp_h  = k / 4;
      exp_hs = (exp_h < sync_w) ? 1'b0 : 1'b1;
      nvec++; if (p  !== exp_p)        begin nerr++; $display("FAIL div_pix[%0d] clk %0d: got %b expected %b", sm, k, p, exp_p); end
      nvec++; if (h  !== 16'(exp_h))   begin nerr++; $display("FAIL div_h[%0d] clk %0d: got %0d expected %0d", sm, k, h, exp_h); end
      nvec++; if (v  !== 16'd0)        begin nerr++; $display("FAIL div_v[%0d] clk %0d: got %0d expected 0", sm, k, v); end
      nvec++; if (hs !== exp_hs)       begin nerr++; $display("FAIL div_hsync[%0d] clk %0d: got %b expected %b", sm, k, hs, exp_hs); end
      nvec++; if (fs !== 1'b0)         begin nerr++; $display("FAIL div_frame_start[%0d] clk %0d: got %b expected 0", sm, k, fs); end
    end
  endtask

  task automatic test_line();
    logic [15:0] prev_h;
    int wraps = 0, ticks = 0, hs_low = 0, over = 0;
    @(negedge clk);
    prev_h = f_h;
    for (int c = 0; c < 10000 && wraps < 2; c++) begin
      @(negedge clk);
      if (f_h > 16'd799) over++;
      if (prev_h == 16'd799 && f_h == 16'd0) begin
        wraps++;
        if (wraps == 1) begin
          nvec++; if (f_v !== 16'd1) begin nerr++; $display("FAIL line_v1: got %0d expected 1", f_v); end
        end else begin
          nvec++; if (ticks != 800)  begin nerr++; $display("FAIL line_ticks: got %0d expected 800", ticks); end
          nvec++; if (hs_low != 96)  begin nerr++; $display("FAIL line_hsync_low: got %0d expected 96", hs_low); end
          nvec++; if (f_v !== 16'd2) begin nerr++; $display("FAIL line_v2: got %0d expected 2", f_v); end
        end
      end
      if (wraps == 1 && f_pix) begin
        ticks++;
        if (!f_hs) hs_low++;
      end
      prev_h = f_h;
    end
    nvec++; if (wraps != 2) begin nerr++; $display("FAIL line_timeout: got %0d wraps expected 2", wraps); end
    nvec++; if (over != 0)  begin nerr++; $display("FAIL line_h_range: got %0d samples above 799 expected 0", over); end
  endtask

  task automatic test_frame();
    logic [15:0] prev_h;
    logic prev_fs;
    int clks = 0, pulses = 0, ticks = 0, lines = 0, vs_low = 0, wide = 0;
    rst_s_n = 1'b1;
    prev_h  = s_h;
    prev_fs = 1'b0;
    for (int c = 0; c < 4000 && pulses < 3; c++) begin
      @(negedge clk);
      clks++;
      if (prev_h == 16'(S_HT - 1) && s_h == 16'd0) lines++;
      if (prev_fs && s_fs) wide++;
      if (s_fs) begin
        pulses++;
        if (pulses == 1) begin
          nvec++; if (clks != 960) begin nerr++; $display("FAIL frame_first_clk: got %0d expected 960", clks); end
          nvec++; if (s_h !== 16'd0 || s_v !== 16'd0) begin nerr++; $display("FAIL frame_pos: got (%0d,%0d) expected (0,0)", s_h, s_v); end
          nvec++; if ({s_hs, s_vs, s_vo} !== 3'b000) begin nerr++; $display("FAIL frame_decode: got %b expected 000", {s_hs, s_vs, s_vo}); end
        end else begin
          nvec++; if (ticks != S_HT * S_VT) begin nerr++; $display("FAIL frame_ticks[%0d]: got %0d expected %0d", pulses, ticks, S_HT * S_VT); end
          nvec++; if (lines != S_VT) begin nerr++; $display("FAIL frame_lines[%0d]: got %0d expected %0d", pulses, lines, S_VT); end
          nvec++; if (vs_low != S_VS * S_HT) begin nerr++; $display("FAIL frame_vsync_low[%0d]: got %0d expected %0d", pulses, vs_low, S_VS * S_HT); end
        end
        ticks  = 0;
        lines  = 0;
        vs_low = 0;
      end
      if (s_pix) begin
        ticks++;
        if (!s_vs) vs_low++;
      end
      prev_h  = s_h;
      prev_fs = s_fs;
    end
    nvec++; if (pulses != 3) begin nerr++; $display("FAIL frame_timeout: got %0d pulses expected 3", pulses); end
    nvec++; if (wide != 0)   begin nerr++; $display("FAIL frame_pulse_width: got %0d wide pulses expected 0", wide); end
  endtask

  task automatic test_window();
    int wh [5] = '{S_HVS - 1, S_HVS, S_HVE - 1, S_HVE, S_HVS};
    int wv [5] = '{S_VVS, S_VVS, S_VVE - 1, S_VVE - 1, S_VVE};
    logic we [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bit found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
        @(negedge clk);
        if (s_h == 16'(wh[i]) && s_v == 16'(wv[i])) found = 1'b1;
      end
      nvec++;
      if (!found) begin
        nerr++; $display("FAIL window_timeout (%0d,%0d): got not reached expected reached", wh[i], wv[i]);
      end else if (s_vo !== we[i]) begin
        nerr++; $display("FAIL window (%0d,%0d): got %b expected %b", wh[i], wv[i], s_vo, we[i]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (s_h == 16'd10 && s_v == 16'd6) found = 1'b1;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL mid_timeout: got not reached expected (10,6)"); end
    nvec++; if ({s_hs, s_vs, s_vo} !== 3'b111) begin nerr++; $display("FAIL mid_pre_decode: got %b expected 111", {s_hs, s_vs, s_vo}); end
    #2;
    rst_s_n = 1'b0;
    #1;
    nvec++; if (s_pix !== 1'b0) begin nerr++; $display("FAIL mid_pix: got %b expected 0", s_pix); end
    nvec++; if (s_h !== 16'd0 || s_v !== 16'd0) begin nerr++; $display("FAIL mid_pos: got (%0d,%0d) expected (0,0)", s_h, s_v); end
    nvec++; if ({s_hs, s_vs, s_vo, s_fs} !== 4'b0000) begin nerr++; $display("FAIL mid_decode: got %b expected 0000", {s_hs, s_vs, s_vo, s_fs}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_divider(1'b1);
  endtask

  initial begin
    rst_f_n = 1'b0;
    rst_s_n = 1'b0;
    test_reset();
    test_divider(1'b0);
    test_line();
    @(negedge clk);
    test_frame();
    test_window();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
